// File: rtl/seq_ctrl_pkg.sv
// Shared types and helpers for the serial sequence-detector controller.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_e;

    // FILL_W: width needed to count 0..PAT_W received bits.
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial data and status bundle of seq_detect_ctrl.
interface seq_detect_ctrl_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_threshold;
    logic             start;
    logic             stop;
    logic             data_valid;
    logic             data_stream;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             timeout;

    modport master (
        output cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold,
        output start, stop, data_valid, data_stream,
        input  cfg_ready, match, match_count, busy, done, timeout
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold,
        input  start, stop, data_valid, data_stream,
        output cfg_ready, match, match_count, busy, done, timeout
    );
endinterface

// File: rtl/seq_match_core.sv
// Shift history, fill tracking and pattern compare for one serial bit per enable.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shift_en,
    input  logic             i_clear,
    input  logic             i_overlap,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_hit_c
);
    localparam int unsigned FILL_W = fill_w(PAT_W);

    logic [PAT_W-2:0] r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0] w_cand;
    logic             w_full;

    assign w_cand  = {r_hist, i_bit};
    assign w_full  = (r_fill >= FILL_W'(PAT_W - 1));
    assign o_hit_c = w_full && (w_cand == i_pattern);

    // Non-overlapping hits restart the window; overlapping hits keep the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift_en) begin
            if (o_hit_c && !i_overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_cand[PAT_W-2:0];
                if (r_fill != FILL_W'(PAT_W))
                    r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Config/arm/sequence controller and match counter around seq_match_core.
// Optional idle-bit timeout enabled by defining SEQ_TIMEOUT_EN.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_ctrl_if.slave   bus
);
    state_e           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic             r_overlap;
    logic [CNT_W-1:0] r_threshold;
    logic [CNT_W-1:0] r_count;
    logic             r_match;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_ready;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_sum;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_match_nxt;
    logic             w_clear_run;
    logic             w_hit_c;
    logic             w_to_expire;

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk        (clk),
        .reset      (reset),
        .i_shift_en ((r_state == ARMED) && bus.data_valid),
        .i_clear    (bus.stop || bus.start),
        .i_overlap  (r_overlap),
        .i_bit      (bus.data_stream),
        .i_pattern  (r_pattern),
        .o_hit_c    (w_hit_c)
    );

    assign w_count_sum = r_count + CNT_W'(1);
    assign w_count_inc = (&r_count) ? r_count : w_count_sum;

    // Next-state: stop beats start, start beats a hit, a hit beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_match_nxt = 1'b0;
        w_clear_run = 1'b0;
        if (bus.stop) begin
            w_state_nxt = IDLE;
        end else if (bus.start) begin
            w_state_nxt = ARMED;
            w_count_nxt = '0;
            w_clear_run = 1'b1;
        end else if ((r_state == ARMED) && bus.data_valid) begin
            if (w_hit_c) begin
                w_match_nxt = 1'b1;
                w_count_nxt = w_count_inc;
                if ((r_threshold != '0) && (w_count_sum == r_threshold))
                    w_state_nxt = DONE;
            end else if (w_to_expire) begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_match     <= w_match_nxt;
            r_busy      <= (w_state_nxt == ARMED);
            r_done      <= (w_state_nxt == DONE);
            r_cfg_ready <= (w_state_nxt != ARMED);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern   <= '0;
            r_overlap   <= 1'b0;
            r_threshold <= '0;
        end else if (bus.cfg_valid && r_cfg_ready) begin
            r_pattern   <= bus.cfg_pattern;
            r_overlap   <= bus.cfg_overlap;
            r_threshold <= bus.cfg_threshold;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_expire = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Counts accepted bits since the last hit or start; sticky flag until next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_clear_run) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (!bus.stop && (r_state == ARMED) && bus.data_valid) begin
            if (w_hit_c || w_to_expire)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);
            if (!w_hit_c && w_to_expire)
                r_timeout <= 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_to;

    assign w_unused_to = (TIMEOUT_CYC == 0);
    assign w_to_expire = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cfg_ready   = r_cfg_ready;

endmodule
